riscv_ifu: RTL and testbench

//  Instruction fetch unit: producer side of the ifu_vld/ifu interface consumed by the IDU.

---
 rtl/riscv_ifu.sv | 141 ++++++++++++++
 tb/tb_riscv_ifu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_ifu (with riscv_pkg)
//  Brief    : Instruction fetch unit. Issues in-order word fetches, buffers
//             returned words in a FIFO and presents {pc, instr} to the IDU.
//  Revision : 1.0 - initial release
// ============================================================================

package riscv_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_t;
endpackage

module riscv_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_data,
  input  logic                 redirect_vld,
  input  logic [31:0]          redirect_pc,
  input  logic                 ifu_rdy,
  output logic                 ifu_vld,
  output riscv_pkg::ifu_t      ifu
);

  localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w:0]   c_depth_x = (c_cnt_w+1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [31:0]        c_word    = 32'd4;

  logic [31:0]           r_fetch_pc;
  logic [31:0]           r_resp_pc;
  logic [c_cnt_w-1:0]    r_outstanding;
  logic [c_cnt_w-1:0]    r_discard;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_ptr_w-1:0]    r_wptr;
  logic [c_ptr_w-1:0]    r_rptr;
  logic                  r_vld;
  riscv_pkg::ifu_t       r_mem [FIFO_DEPTH];

  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [c_cnt_w-1:0]    w_count_nxt;
  logic [c_cnt_w-1:0]    w_outstanding_nxt;
  logic [31:0]           w_redir_pc;
  logic                  w_unused;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused   = ^redirect_pc[1:0];

  // Credits cover both words in flight and words already buffered.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_depth_x;
  assign imem_req    = !reset && !redirect_vld && w_credit_ok;
  assign imem_addr   = r_fetch_pc;
  assign w_issue     = imem_req && imem_gnt;

  assign w_drop = imem_ack && (r_discard != '0);
  assign w_push = imem_ack && !w_drop && !redirect_vld;
  assign w_pop  = r_vld && ifu_rdy && !redirect_vld;

  assign ifu_vld = r_vld;
  assign ifu     = r_vld ? r_mem[r_rptr] : '0;

  always_comb begin
    w_outstanding_nxt = r_outstanding + c_cnt_w'(w_issue) - c_cnt_w'(imem_ack);
    w_count_nxt       = r_count;
    if (redirect_vld) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_vld         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_count       <= w_count_nxt;
      r_vld         <= (w_count_nxt != '0);
      if (redirect_vld) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        // Every word still in flight after this cycle is stale, whether or
        // not an earlier redirect had already marked it for dropping.
        r_discard  <= r_outstanding - c_cnt_w'(imem_ack);
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + c_word;
        end
        if (w_drop) begin
          r_discard <= r_discard - c_cnt_w'(1);
        end
        if (w_push) begin
          r_mem[r_wptr] <= '{pc: r_resp_pc, instr: imem_data};
          r_wptr        <= r_wptr + c_ptr_one;
          r_resp_pc     <= r_resp_pc + c_word;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + c_ptr_one;
        end
      end
    end
  end

  a_addr_stable : assert property (@(posedge clock) disable iff (reset)
    (imem_req && !imem_gnt) |=> (!imem_req || $stable(imem_addr)));

  a_ifu_stable : assert property (@(posedge clock) disable iff (reset)
    (ifu_vld && !ifu_rdy && !redirect_vld) |=> $stable(ifu));

  a_ifu_known : assert property (@(posedge clock) disable iff (reset)
    ifu_vld |-> !$isunknown(ifu));

endmodule

`default_nettype wire

// File: tb/tb_riscv_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_ifu
//  Brief    : Randomized self-checking bench for riscv_ifu against a
//             queue-based reference model and an in-order memory model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_riscv_ifu;

  localparam int          c_depth    = 4;
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  logic            clock;
  logic            reset;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic            redirect_vld;
  logic [31:0]     redirect_pc;
  logic            ifu_rdy;
  logic            ifu_vld;
  riscv_pkg::ifu_t ifu;

  riscv_ifu #(
    .RESET_PC   (c_reset_pc),
    .FIFO_DEPTH (c_depth)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .ifu_rdy      (ifu_rdy),
    .ifu_vld      (ifu_vld),
    .ifu          (ifu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;

  // Reference model: words in flight (oldest first) and words the IDU should see.
  infl_t           m_infl[$];
  riscv_pkg::ifu_t m_fifo[$];
  logic [31:0]     m_fetch_pc;

  // Memory environment: addresses actually issued by the DUT and their issue cycle.
  logic [31:0]     mem_addr_q[$];
  int              mem_cyc_q[$];

  int n_cmp;
  int n_err;
  int cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_infl.delete();
    m_fifo.delete();
    mem_addr_q.delete();
    mem_cyc_q.delete();
    m_fetch_pc = c_reset_pc;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset        = 1'b1;
    redirect_vld = 1'b0;
    imem_ack     = 1'b0;
    imem_gnt     = 1'b0;
    ifu_rdy      = 1'b0;
    repeat (cycles) @(negedge clock);
    check("rst_ifu_vld", {63'd0, ifu_vld}, 64'd0);
    check("rst_ifu", ifu, 64'd0);
    check("rst_imem_req", {63'd0, imem_req}, 64'd0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input int p_gnt, input int p_ack, input int p_rdy, input int p_redir);
    bit              exp_req;
    bit              ack_push;
    infl_t           e;
    riscv_pkg::ifu_t exp_ifu;
    @(negedge clock);
    redirect_vld = ($urandom_range(99) < p_redir);
    case ($urandom_range(3))
      0:       redirect_pc = $urandom;
      1:       redirect_pc = 32'hFFFF_FFFC;
      2:       redirect_pc = 32'h0000_0013;
      default: redirect_pc = 32'h0000_0100;
    endcase
    imem_gnt = ($urandom_range(99) < p_gnt);
    ifu_rdy  = ($urandom_range(99) < p_rdy);
    imem_ack = (mem_addr_q.size() > 0) && (mem_cyc_q[0] < cyc) && ($urandom_range(99) < p_ack);
    imem_data = imem_ack ? mem_word(mem_addr_q[0]) : $urandom;
    #1;
    exp_req = !redirect_vld && ((m_infl.size() + m_fifo.size()) < c_depth);
    exp_ifu = (m_fifo.size() > 0) ? m_fifo[0] : '0;
    check("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (exp_req) check("imem_addr", {32'd0, imem_addr}, {32'd0, m_fetch_pc});
    check("ifu_vld", {63'd0, ifu_vld}, {63'd0, (m_fifo.size() > 0)});
    check("ifu", ifu, exp_ifu);

    if (imem_ack) begin
      void'(mem_addr_q.pop_front());
      void'(mem_cyc_q.pop_front());
    end
    if (imem_req && imem_gnt) begin
      mem_addr_q.push_back(imem_addr);
      mem_cyc_q.push_back(cyc);
    end

    ack_push = 1'b0;
    e        = '{pc: 32'd0, stale: 1'b1};
    if (imem_ack && m_infl.size() > 0) e = m_infl.pop_front();
    if (redirect_vld) begin
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fifo.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_ack && !e.stale) ack_push = 1'b1;
      if (m_fifo.size() > 0 && ifu_rdy) void'(m_fifo.pop_front());
      if (ack_push) m_fifo.push_back('{pc: e.pc, instr: mem_word(e.pc)});
      if (exp_req && imem_gnt) begin
        m_infl.push_back('{pc: m_fetch_pc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    cyc          = 0;
    reset        = 1'b1;
    imem_gnt     = 1'b0;
    imem_ack     = 1'b0;
    imem_data    = '0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    ifu_rdy      = 1'b0;
    model_reset();

    do_reset(3);
    // Full-rate streaming from reset.
    repeat (30) step(100, 100, 100, 0);
    // Stalled consumer: FIFO fills and issue stops.
    repeat (20) step(100, 100, 0, 0);
    repeat (20) step(100, 100, 100, 0);
    // Random traffic with occasional redirects.
    repeat (3000) step(70, 60, 60, 5);
    // Dense, often back-to-back redirects with slow memory.
    repeat (1000) step(80, 40, 70, 40);
    // Reset in the middle of traffic.
    do_reset(2);
    repeat (2000) step(90, 80, 50, 8);
    repeat (500) step(100, 100, 100, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
